// File: rtl/nibble_pair_sched.sv
// Pairs two 4-bit nibbles from one of two requesters into a byte {lo, hi}.
// A requester that wins in IDLE keeps the lock until its second nibble lands.
module nibble_pair_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       in0_valid,
  input  logic [3:0] in0_nib,
  output logic       in0_ready,
  input  logic       in1_valid,
  input  logic [3:0] in1_nib,
  output logic       in1_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_src,
  input  logic       out_ready,
  output logic [7:0] pair_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. Producers hold valid/data until accepted; ready never waits on a
  // later cycle's valid.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_HI = 2'd1,
    OUT    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       prio;
  logic       lock_src;
  logic [3:0] lo_q;
  logic       grant;
  logic       hs0;
  logic       hs1;
  logic       nib_hs;
  logic [3:0] nib;
  logic       out_hs;

  // Round-robin: the priority bit only matters when both requesters are valid.
  always_comb begin
    grant = 1'b0;
    if (in0_valid && in1_valid) grant = prio;
    else                        grant = in1_valid;
  end

  // Output process; rst gates the readies so they drop asynchronously.
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          in0_ready = in0_valid && !grant;
          in1_ready = in1_valid && grant;
        end
        GET_HI: begin
          in0_ready = !lock_src;
          in1_ready = lock_src;
        end
        OUT:     out_valid = 1'b1;
        default: out_valid = 1'b0;
      endcase
    end
  end

  assign hs0    = in0_valid && in0_ready;
  assign hs1    = in1_valid && in1_ready;
  assign nib_hs = hs0 || hs1;
  assign nib    = hs1 ? in1_nib : in0_nib;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (nib_hs) state_nx = GET_HI;
      GET_HI:  if (nib_hs) state_nx = OUT;
      OUT:     if (out_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // The lo nibble is staged in lo_q so out_data/out_src only change when a
  // complete byte is formed, and stay put through IDLE and GET_HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q       <= 4'h0;
      lock_src   <= 1'b0;
      out_data   <= 8'h00;
      out_src    <= 1'b0;
      pair_count <= 8'h00;
      prio       <= 1'b0;
    end else begin
      if (state == IDLE && nib_hs) begin
        lo_q     <= nib;
        lock_src <= hs1;
      end
      if (state == GET_HI && nib_hs) begin
        out_data <= {lo_q, nib};
        out_src  <= lock_src;
      end
      if (out_hs) begin
        pair_count <= pair_count + 8'd1;
        prio       <= ~out_src;
      end
    end
  end

endmodule

// File: tb/tb_nibble_pair_sched.sv
// Directed bench for nibble_pair_sched: reset, arbitration, lock, backpressure,
// mid-pair reset and pair_count wrap, with hand-computed expectations.
module tb_nibble_pair_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid;
  logic [3:0] in0_nib;
  logic       in0_ready;
  logic       in1_valid;
  logic [3:0] in1_nib;
  logic       in1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_ready;
  logic [7:0] pair_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_pair_sched dut (
    .clk        (clk),
    .rst        (rst),
    .in0_valid  (in0_valid),
    .in0_nib    (in0_nib),
    .in0_ready  (in0_ready),
    .in1_valid  (in1_valid),
    .in1_nib    (in1_nib),
    .in1_ready  (in1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .pair_count (pair_count)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drive(input logic v0, input logic [3:0] n0, input logic v1, input logic [3:0] n1);
    in0_valid = v0;
    in0_nib   = n0;
    in1_valid = v1;
    in1_nib   = n1;
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_pair_count", pair_count, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in0_ready", {7'd0, in0_ready}, 8'd0);
    chk("rst_in1_ready", {7'd0, in1_ready}, 8'd0);
    nxt();
    rst = 1'b0;
  endtask

  logic [3:0] l0, h0, l1, h1;
  logic [7:0] exp_byte;

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 4'h0, 1'b1, 4'h0);

    // Reset values with both requesters valid.
    nxt(); #1;
    chk("reset_out_valid", {7'd0, out_valid}, 8'd0);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_out_src", {7'd0, out_src}, 8'd0);
    chk("reset_pair_count", pair_count, 8'h00);
    chk("reset_in0_ready", {7'd0, in0_ready}, 8'd0);
    chk("reset_in1_ready", {7'd0, in1_ready}, 8'd0);

    // Req0 alone sends 0xC, 0x8.
    nxt();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 4'hC, 1'b0, 4'h0);
    #1;
    chk("b1_idle_in0_ready", {7'd0, in0_ready}, 8'd1);
    chk("b1_idle_in1_ready", {7'd0, in1_ready}, 8'd0);
    nxt();
    drive(1'b1, 4'h8, 1'b0, 4'h0);
    #1;
    chk("b1_gethi_in0_ready", {7'd0, in0_ready}, 8'd1);
    chk("b1_gethi_out_valid", {7'd0, out_valid}, 8'd0);
    nxt();
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    #1;
    chk("b1_out_valid", {7'd0, out_valid}, 8'd1);
    chk("b1_out_data", out_data, 8'hC8);
    chk("b1_out_data_dec", out_data, 8'd200);
    chk("b1_out_src", {7'd0, out_src}, 8'd0);
    chk("b1_out_in0_ready", {7'd0, in0_ready}, 8'd0);
    nxt(); #1;
    chk("b1_after_out_valid", {7'd0, out_valid}, 8'd0);
    chk("b1_after_count", pair_count, 8'd1);
    chk("b1_hold_data", out_data, 8'hC8);

    // Both valid from reset: 0x12 from req0, then 0x34 from req1.
    do_reset();
    drive(1'b1, 4'h1, 1'b1, 4'h3);
    #1;
    chk("rr_idle0_in0_ready", {7'd0, in0_ready}, 8'd1);
    chk("rr_idle0_in1_ready", {7'd0, in1_ready}, 8'd0);
    nxt();
    drive(1'b1, 4'h2, 1'b1, 4'h3);
    #1;
    chk("rr_gethi0_in0_ready", {7'd0, in0_ready}, 8'd1);
    chk("rr_gethi0_in1_ready", {7'd0, in1_ready}, 8'd0);
    nxt(); #1;
    chk("rr_byte0_data", out_data, 8'h12);
    chk("rr_byte0_src", {7'd0, out_src}, 8'd0);
    nxt();
    drive(1'b1, 4'h9, 1'b1, 4'h3);
    #1;
    chk("rr_idle1_in0_ready", {7'd0, in0_ready}, 8'd0);
    chk("rr_idle1_in1_ready", {7'd0, in1_ready}, 8'd1);
    nxt();
    drive(1'b1, 4'h9, 1'b1, 4'h4);
    #1;
    chk("rr_gethi1_in0_ready", {7'd0, in0_ready}, 8'd0);
    chk("rr_gethi1_in1_ready", {7'd0, in1_ready}, 8'd1);
    nxt(); #1;
    chk("rr_byte1_data", out_data, 8'h34);
    chk("rr_byte1_src", {7'd0, out_src}, 8'd1);
    nxt(); #1;
    chk("rr_count", pair_count, 8'd2);

    // Lock: req0 owns the pair, req1 waits out four cycles with ready low.
    drive(1'b1, 4'hD, 1'b0, 4'h0);
    nxt();
    drive(1'b0, 4'h0, 1'b1, 4'hE);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lock_in1_ready", {7'd0, in1_ready}, 8'd0);
      chk("lock_in0_ready", {7'd0, in0_ready}, 8'd1);
      chk("lock_out_valid", {7'd0, out_valid}, 8'd0);
      nxt();
    end
    drive(1'b1, 4'h5, 1'b1, 4'hE);
    nxt();
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    #1;
    chk("lock_data", out_data, 8'hD5);
    chk("lock_src", {7'd0, out_src}, 8'd0);
    nxt(); #1;
    chk("lock_count", pair_count, 8'd3);

    // Backpressure: req1 sends 0xA, 0xB; out_ready low for five OUT cycles.
    out_ready = 1'b0;
    drive(1'b0, 4'h0, 1'b1, 4'hA);
    nxt();
    drive(1'b0, 4'h0, 1'b1, 4'hB);
    nxt();
    drive(1'b1, 4'h1, 1'b1, 4'h2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_out_valid", {7'd0, out_valid}, 8'd1);
      chk("bp_out_data", out_data, 8'hAB);
      chk("bp_out_src", {7'd0, out_src}, 8'd1);
      chk("bp_in0_ready", {7'd0, in0_ready}, 8'd0);
      chk("bp_in1_ready", {7'd0, in1_ready}, 8'd0);
      chk("bp_count", pair_count, 8'd3);
      nxt();
    end
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    out_ready = 1'b1;
    nxt(); #1;
    chk("bp_accept_count", pair_count, 8'd4);
    chk("bp_accept_valid", {7'd0, out_valid}, 8'd0);

    // Reset while in GET_HI after lo=0xA discards the partial byte.
    drive(1'b1, 4'hA, 1'b0, 4'h0);
    nxt();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("midrst_count", pair_count, 8'd0);
    chk("midrst_in0_ready", {7'd0, in0_ready}, 8'd0);
    nxt();
    rst = 1'b0;
    drive(1'b1, 4'h6, 1'b0, 4'h0);
    #1;
    chk("postrst_in0_ready", {7'd0, in0_ready}, 8'd1);
    chk("postrst_out_data", out_data, 8'h00);
    nxt();
    drive(1'b1, 4'h7, 1'b0, 4'h0);
    nxt();
    drive(1'b0, 4'h0, 1'b0, 4'h0);
    #1;
    chk("postrst_data", out_data, 8'h67);
    chk("postrst_src", {7'd0, out_src}, 8'd0);
    nxt(); #1;
    chk("postrst_count", pair_count, 8'd1);

    // 256 bytes with both requesters always valid: sources alternate, count wraps.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      l0 = 4'($urandom_range(0, 15));
      l1 = 4'($urandom_range(0, 15));
      h0 = 4'($urandom_range(0, 15));
      h1 = 4'($urandom_range(0, 15));
      drive(1'b1, l0, 1'b1, l1);
      nxt();
      drive(1'b1, h0, 1'b1, h1);
      nxt(); #1;
      exp_byte = (i % 2 == 1) ? {l1, h1} : {l0, h0};
      chk("wrap_data", out_data, exp_byte);
      chk("wrap_src", {7'd0, out_src}, 8'(i % 2));
      if (i == 255) chk("wrap_count_255", pair_count, 8'd255);
      nxt();
    end
    #1;
    chk("wrap_count_0", pair_count, 8'h00);
    chk("wrap_out_valid", {7'd0, out_valid}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
